uart_seq_trig: RTL and testbench

Parametrised UART protocol trigger for the logic-analyzer capture path. It is the successor to the fixed 8-bit, single-frame UART trigger. It contains its own oversampling receiver and fires `protTrig` when the last `SEQ_LEN` received words match a masked multi-word pattern. `protTrig` feeds the trigger-combine logic in place of the old UART trigger output.

---
 rtl/uart_seq_trig_if.sv | 26 ++
 rtl/uart_seq_trig.sv | 218 +++++++++++++++++++++
 tb/tb_uart_seq_trig.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_seq_trig_if.sv
// Signal bundle between the capture-path controller and the UART protocol trigger.
interface uart_seq_trig_if #(
   parameter int DATA_W  = 8,
   parameter int SEQ_LEN = 2,
   parameter int BAUD_W  = 16
) ();
   logic                        RX;
   logic [BAUD_W-1:0]           baud_cnt;
   logic [SEQ_LEN*DATA_W-1:0]   match;
   logic [SEQ_LEN*DATA_W-1:0]   mask;
   logic                        arm;
   logic                        protTrig;
   logic [DATA_W-1:0]           rx_data;
   logic                        rx_vld;
   logic                        frame_err;

   modport master (
      output RX, baud_cnt, match, mask, arm,
      input  protTrig, rx_data, rx_vld, frame_err
   );

   modport slave (
      input  RX, baud_cnt, match, mask, arm,
      output protTrig, rx_data, rx_vld, frame_err
   );
endinterface

// File: rtl/uart_seq_trig.sv
// Oversampling UART receiver with a sliding multi-word masked pattern trigger.
// Define UART_TRIG_PARITY_EN to add an even-parity bit after the data bits.
module uart_seq_trig #(
   parameter int DATA_W  = 8,
   parameter int SEQ_LEN = 2,
   parameter int BAUD_W  = 16
) (
   input  logic           clk,
   input  logic           rst,
   uart_seq_trig_if.slave bus
);
   localparam int HW    = SEQ_LEN * DATA_W;
   localparam int BIT_W = $clog2(DATA_W);
   localparam int CNT_W = $clog2(SEQ_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SEQ_LEN);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TRIG_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif

   logic              rx_meta_q, rxs_q, rxs_prev_q;
   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] tmr_q, tmr_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shr_q, shr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_vld_q, rx_vld_d;
   logic              frame_err_q, frame_err_d;
   logic [HW-1:0]     hist_q, hist_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              chk_q, chk_d;
   logic              prot_q, prot_d;
   logic              par_ok;

   logic [BAUD_W-1:0] baud_eff, full_ld, half_ld;
   logic              expire, word_done, word_bad, hit;
   logic [SEQ_LEN-1:0] word_hit;
   logic [HW+DATA_W-1:0] hist_ext;

   // Small baud values would make the half-bit load underflow, so clamp to 4.
   assign baud_eff = (bus.baud_cnt < BAUD_W'(4)) ? BAUD_W'(4) : bus.baud_cnt;
   assign full_ld  = baud_eff - BAUD_W'(1);
   assign half_ld  = (baud_eff >> 1) - BAUD_W'(1);
   assign expire   = (tmr_q == '0);

`ifdef UART_TRIG_PARITY_EN
   logic par_err_q, par_err_d;
   assign par_ok = ~par_err_q;
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= bus.RX;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_d     = bit_q;
      shr_d     = shr_q;
      word_done = 1'b0;
      word_bad  = 1'b0;
`ifdef UART_TRIG_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               state_d = ST_START;
               tmr_d   = half_ld;
            end
         end
         ST_START: begin
            if (expire) begin
               if (!rxs_q) begin
                  state_d = ST_DATA;
                  tmr_d   = full_ld;
                  bit_d   = '0;
`ifdef UART_TRIG_PARITY_EN
                  par_err_d = 1'b0;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q - BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (expire) begin
               shr_d = {rxs_q, shr_q[DATA_W-1:1]};
               tmr_d = full_ld;
               bit_d = bit_q + BIT_W'(1);
               if (bit_q == LAST_BIT) begin
`ifdef UART_TRIG_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               tmr_d = tmr_q - BAUD_W'(1);
            end
         end
`ifdef UART_TRIG_PARITY_EN
         ST_PARITY: begin
            if (expire) begin
               par_err_d = rxs_q ^ (^shr_q);
               state_d   = ST_STOP;
               tmr_d     = full_ld;
            end else begin
               tmr_d = tmr_q - BAUD_W'(1);
            end
         end
`endif
         ST_STOP: begin
            // Returning to IDLE at the sample point leaves half a bit to catch the next start edge.
            if (expire) begin
               state_d = ST_IDLE;
               if (rxs_q && par_ok) word_done = 1'b1;
               else                 word_bad  = 1'b1;
            end else begin
               tmr_d = tmr_q - BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < SEQ_LEN; g++) begin : g_word
         assign word_hit[g] = ~|((hist_q[g*DATA_W +: DATA_W] ^ bus.match[g*DATA_W +: DATA_W])
                                 & ~bus.mask[g*DATA_W +: DATA_W]);
      end
   endgenerate

   assign hit      = (cnt_q == CNT_MAX) && (&word_hit);
   assign hist_ext = {shr_q, hist_q} >> DATA_W;

   always_comb begin
      rx_vld_d    = word_done;
      frame_err_d = word_bad;
      rx_data_d   = word_done ? shr_q : rx_data_q;
      hist_d      = hist_q;
      cnt_d       = cnt_q;
      chk_d       = 1'b0;
      prot_d      = prot_q;
      // arm outranks both a coincident match and a coincident push.
      if (bus.arm) begin
         prot_d = 1'b0;
         cnt_d  = '0;
      end else begin
         if (chk_q && hit) prot_d = 1'b1;
         if (word_bad) begin
            cnt_d = '0;
         end else if (word_done) begin
            hist_d = hist_ext[HW-1:0];
            cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            chk_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         bit_q       <= '0;
         shr_q       <= '0;
         rx_data_q   <= '0;
         rx_vld_q    <= 1'b0;
         frame_err_q <= 1'b0;
         hist_q      <= '0;
         cnt_q       <= '0;
         chk_q       <= 1'b0;
         prot_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         bit_q       <= bit_d;
         shr_q       <= shr_d;
         rx_data_q   <= rx_data_d;
         rx_vld_q    <= rx_vld_d;
         frame_err_q <= frame_err_d;
         hist_q      <= hist_d;
         cnt_q       <= cnt_d;
         chk_q       <= chk_d;
         prot_q      <= prot_d;
      end
   end

`ifdef UART_TRIG_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_err_q <= 1'b0;
      else     par_err_q <= par_err_d;
   end
`endif

   assign bus.protTrig  = prot_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_vld    = rx_vld_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_seq_trig.sv
// Directed bench for uart_seq_trig: pattern hit, overlap, mask, frame error, false start, reset.
module tb_uart_seq_trig;
   localparam int DW  = 8;
   localparam int SL  = 2;
   localparam int BW  = 16;
   localparam int BIT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_seq_trig_if #(.DATA_W(DW), .SEQ_LEN(SL), .BAUD_W(BW)) bus ();

   uart_seq_trig #(.DATA_W(DW), .SEQ_LEN(SL), .BAUD_W(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0, vld_n = 0, err_n = 0, vld_cyc = 0, rise_cyc = 0;
   int v0, e0;
   logic trig_prev = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.rx_vld) begin
         vld_n   <= vld_n + 1;
         vld_cyc <= cyc;
      end
      if (bus.frame_err) err_n <= err_n + 1;
      if (bus.protTrig && !trig_prev) rise_cyc <= cyc;
      trig_prev <= bus.protTrig;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic stop_b, input int bt);
      bus.RX = 1'b0;
      tick(bt);
      for (int i = 0; i < 8; i++) begin
         bus.RX = b[i];
         tick(bt);
      end
      bus.RX = stop_b;
      tick(bt);
      bus.RX = 1'b1;
   endtask

   task automatic pulse_arm();
      bus.arm = 1'b1;
      tick(1);
      bus.arm = 1'b0;
      tick(1);
   endtask

   initial begin
      bus.RX       = 1'b1;
      bus.baud_cnt = 16'd16;
      bus.match    = 16'h3CA5;
      bus.mask     = 16'h0000;
      bus.arm      = 1'b0;
      rst          = 1'b1;
      tick(3);
      chk("rst_trig", 32'(bus.protTrig), 32'd0);
      chk("rst_data", 32'(bus.rx_data), 32'd0);
      chk("rst_vld", 32'(bus.rx_vld), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      rst = 1'b0;
      tick(5);

      // basic two-word hit
      v0 = vld_n;
      send(8'hA5, 1'b1, BIT);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("basic_vld_cnt", 32'(vld_n - v0), 32'd2);
      chk("basic_data", 32'(bus.rx_data), 32'h3C);
      chk("basic_trig", 32'(bus.protTrig), 32'd1);
      chk("basic_lag", 32'(rise_cyc - vld_cyc), 32'd1);
      tick(50);
      chk("basic_sticky", 32'(bus.protTrig), 32'd1);
      pulse_arm();
      chk("basic_arm", 32'(bus.protTrig), 32'd0);

      // overlapping sequence
      send(8'hA5, 1'b1, BIT);
      send(8'hA5, 1'b1, BIT);
      tick(10);
      chk("ovl_no_trig", 32'(bus.protTrig), 32'd0);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("ovl_trig", 32'(bus.protTrig), 32'd1);
      pulse_arm();

      // masked pattern
      bus.mask  = 16'h000F;
      bus.match = 16'h3CA0;
      send(8'hAF, 1'b1, BIT);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("mask_trig", 32'(bus.protTrig), 32'd1);
      pulse_arm();
      send(8'hBF, 1'b1, BIT);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("mask_no_trig", 32'(bus.protTrig), 32'd0);
      bus.mask  = 16'h0000;
      bus.match = 16'h3CA5;
      pulse_arm();

      // frame error clears history and keeps rx_data
      v0 = vld_n;
      e0 = err_n;
      send(8'hA5, 1'b1, BIT);
      send(8'h11, 1'b0, BIT);
      tick(BIT);
      chk("ferr_data_kept", 32'(bus.rx_data), 32'hA5);
      chk("ferr_one_pulse", 32'(err_n - e0), 32'd1);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("ferr_vld_cnt", 32'(vld_n - v0), 32'd2);
      chk("ferr_err_cnt", 32'(err_n - e0), 32'd1);
      chk("ferr_data", 32'(bus.rx_data), 32'h3C);
      chk("ferr_no_trig", 32'(bus.protTrig), 32'd0);

      // false start
      v0 = vld_n;
      e0 = err_n;
      bus.RX = 1'b0;
      tick(4);
      bus.RX = 1'b1;
      tick(40);
      chk("fs_no_vld", 32'(vld_n - v0), 32'd0);
      chk("fs_no_err", 32'(err_n - e0), 32'd0);
      send(8'h55, 1'b1, BIT);
      tick(10);
      chk("fs_next_data", 32'(bus.rx_data), 32'h55);
      chk("fs_next_vld", 32'(vld_n - v0), 32'd1);

      // reset during the 4th data bit
      send(8'hA5, 1'b1, BIT);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("pre_rst_trig", 32'(bus.protTrig), 32'd1);
      v0 = vld_n;
      bus.RX = 1'b0; tick(BIT);
      bus.RX = 1'b1; tick(BIT);
      bus.RX = 1'b0; tick(BIT);
      bus.RX = 1'b1; tick(BIT);
      bus.RX = 1'b0; tick(8);
      rst = 1'b1;
      #1;
      chk("mid_rst_trig", 32'(bus.protTrig), 32'd0);
      chk("mid_rst_data", 32'(bus.rx_data), 32'd0);
      chk("mid_rst_vld", 32'(bus.rx_vld), 32'd0);
      chk("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
      bus.RX = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      chk("post_rst_no_vld", 32'(vld_n - v0), 32'd0);
      send(8'hA5, 1'b1, BIT);
      send(8'h3C, 1'b1, BIT);
      tick(10);
      chk("post_rst_data", 32'(bus.rx_data), 32'h3C);
      chk("post_rst_trig", 32'(bus.protTrig), 32'd1);

      // baud_cnt below 4 behaves as 4
      pulse_arm();
      bus.baud_cnt = 16'd2;
      tick(2);
      send(8'h96, 1'b1, 4);
      tick(10);
      chk("baud_clamp_data", 32'(bus.rx_data), 32'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
